// File: rtl/io_collect_reader.sv
// io_collect_reader: host-side initiator for the data-collection IO block.
// Sequence per transfer: start write, wait for interrupt (with timeout),
// paced burst read of the capture buffer into a 2-entry output buffer with a
// running checksum, acknowledge write, then drain and pulse done.
module io_collect_reader #(
    parameter logic [15:0] START_ADDR = 16'h5000,
    parameter logic [15:0] ACK_ADDR   = 16'h5001,
    parameter logic [15:0] BUF_BASE   = 16'h5500,
    parameter int          NUM_BYTES  = 256,
    parameter int          TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        interrupt,
    input  logic [7:0]  rd_data,
    output logic [15:0] addr,
    output logic        write_IO,
    output logic        read_IO,
    output logic        get_data,
    output logic [7:0]  byte_out,
    output logic [7:0]  byte_idx,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [7:0]  checksum
);

    localparam int              TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]      NB        = 9'(NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_START_WR, S_WAIT_IRQ, S_READ, S_ACK_WR, S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic          write_q, write_d;
    logic          read_q, read_d;
    logic          pend_q, pend_d;       // a read was on the bus last cycle; its data lands now
    logic [8:0]    issue_q, issue_d;
    logic [8:0]    recv_q, recv_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [7:0]    head_data_q, head_data_d, head_idx_q, head_idx_d;
    logic [7:0]    tail_data_q, tail_data_d, tail_idx_q, tail_idx_d;
    logic [1:0]    count_q, count_d;
    logic          valid_q, valid_d;
    logic [7:0]    checksum_q, checksum_d;
    logic          timeout_q, timeout_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic          pop, push;
    logic [1:0]    cnt_after_pop;
    logic [2:0]    occ;
    logic          can_issue;

    // Next-state, bus, buffer and checksum logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        pend_d      = read_q;
        issue_d     = issue_q;
        recv_d      = recv_q;
        wait_d      = wait_q;
        head_data_d = head_data_q;
        head_idx_d  = head_idx_q;
        tail_data_d = tail_data_q;
        tail_idx_d  = tail_idx_q;
        checksum_d  = checksum_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;

        pop  = valid_q & byte_ready;
        push = pend_q;

        // Two-slot buffer: head is always the output register, tail refills it.
        cnt_after_pop = count_q - {1'b0, pop};
        if (pop) begin
            head_data_d = tail_data_q;
            head_idx_d  = tail_idx_q;
        end
        if (push) begin
            if (cnt_after_pop == 2'd0) begin
                head_data_d = rd_data;
                head_idx_d  = recv_q[7:0];
            end else begin
                tail_data_d = rd_data;
                tail_idx_d  = recv_q[7:0];
            end
            checksum_d = checksum_q + rd_data;
            recv_d     = recv_q + 9'd1;
        end
        count_d = cnt_after_pop + {1'b0, push};

        // Reads still on the bus or landing count against free space, so a
        // landing byte always finds a slot even if the consumer stalls.
        occ       = {1'b0, count_q} + {2'b0, read_q} + {2'b0, pend_q} - {2'b0, pop};
        can_issue = (issue_q < NB) && (occ < 3'd2);

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d    = S_START_WR;
                    checksum_d = 8'd0;
                    timeout_d  = 1'b0;
                    issue_d    = 9'd0;
                    recv_d     = 9'd0;
                    write_d    = 1'b1;
                    addr_d     = START_ADDR;
                end
            end
            S_START_WR: begin
                state_d = S_WAIT_IRQ;
                wait_d  = '0;
            end
            S_WAIT_IRQ: begin
                if (interrupt) begin
                    // First read goes out in the first READ cycle.
                    state_d = S_READ;
                    read_d  = 1'b1;
                    addr_d  = BUF_BASE;
                    issue_d = 9'd1;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_ACK_WR;
                    write_d   = 1'b1;
                    addr_d    = ACK_ADDR;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            S_READ: begin
                if (recv_d == NB) begin
                    state_d = S_ACK_WR;
                    write_d = 1'b1;
                    addr_d  = ACK_ADDR;
                end else if (can_issue) begin
                    read_d  = 1'b1;
                    addr_d  = BUF_BASE + {7'b0, issue_q};
                    issue_d = issue_q + 9'd1;
                end
            end
            S_ACK_WR: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (count_d != 2'd0);
        busy_d  = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'd0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            pend_q      <= 1'b0;
            issue_q     <= 9'd0;
            recv_q      <= 9'd0;
            wait_q      <= '0;
            head_data_q <= 8'd0;
            head_idx_q  <= 8'd0;
            tail_data_q <= 8'd0;
            tail_idx_q  <= 8'd0;
            count_q     <= 2'd0;
            valid_q     <= 1'b0;
            checksum_q  <= 8'd0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            read_q      <= read_d;
            pend_q      <= pend_d;
            issue_q     <= issue_d;
            recv_q      <= recv_d;
            wait_q      <= wait_d;
            head_data_q <= head_data_d;
            head_idx_q  <= head_idx_d;
            tail_data_q <= tail_data_d;
            tail_idx_q  <= tail_idx_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            checksum_q  <= checksum_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign addr        = addr_q;
    assign write_IO    = write_q;
    assign read_IO     = read_q;
    assign get_data    = read_q;
    assign byte_out    = head_data_q;
    assign byte_idx    = head_idx_q;
    assign byte_valid  = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign checksum    = checksum_q;

endmodule

// File: tb/tb_io_collect_reader.sv
// Bench for io_collect_reader: a bus responder serves reads and pushes the
// expected bytes into a scoreboard queue; a monitor pops on every accepted
// byte and also checks bus addresses, strobes and buffer occupancy.
module tb_io_collect_reader;

    localparam logic [15:0] START = 16'h5000;
    localparam logic [15:0] ACK   = 16'h5001;
    localparam logic [15:0] BASE  = 16'h5500;
    localparam int          NB    = 256;
    localparam int          TMO   = 16;
    localparam int          SNB   = 4;

    logic clk, rst, go, interrupt, byte_ready;
    logic [7:0]  rd_data, byte_out, byte_idx, checksum;
    logic [15:0] addr;
    logic write_IO, read_IO, get_data, byte_valid, busy, done, timeout_err;

    logic s_go, s_interrupt, s_byte_ready;
    logic [7:0]  s_rd_data, s_byte_out, s_byte_idx, s_checksum;
    logic [15:0] s_addr;
    logic s_write_IO, s_read_IO, s_get_data, s_byte_valid, s_busy, s_done, s_timeout_err;

    io_collect_reader #(.NUM_BYTES(NB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .go(go), .interrupt(interrupt), .rd_data(rd_data),
        .addr(addr), .write_IO(write_IO), .read_IO(read_IO), .get_data(get_data),
        .byte_out(byte_out), .byte_idx(byte_idx), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .busy(busy), .done(done),
        .timeout_err(timeout_err), .checksum(checksum));

    io_collect_reader #(.NUM_BYTES(SNB), .TIMEOUT(TMO)) sdut (
        .clk(clk), .rst(rst), .go(s_go), .interrupt(s_interrupt), .rd_data(s_rd_data),
        .addr(s_addr), .write_IO(s_write_IO), .read_IO(s_read_IO), .get_data(s_get_data),
        .byte_out(s_byte_out), .byte_idx(s_byte_idx), .byte_valid(s_byte_valid),
        .byte_ready(s_byte_ready), .busy(s_busy), .done(s_done),
        .timeout_err(s_timeout_err), .checksum(s_checksum));

    typedef struct {
        logic [7:0] data;
        logic [7:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, passed = 0;
    int          data_mode = 0, ready_mode = 0;
    int          n_reads, n_start, n_ack, n_done, n_acc, cyc, start_cyc, ack_cyc;
    logic        ack_tmo;
    logic [7:0]  sum_model;
    logic        resp_pend = 1'b0;
    logic [15:0] resp_addr = 16'd0;
    int          s_reads = 0, s_done_n = 0, s_acc = 0;
    logic        s_resp_pend = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus responder: rd_data valid the cycle after a read strobe, junk otherwise
    initial begin
        logic [7:0] d;
        rd_data = 8'd0;
        s_rd_data = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_pend && !rst) begin
                case (data_mode)
                    0: d = resp_addr[7:0];
                    1: d = 8'hFF;
                    default: d = 8'($urandom);
                endcase
                rd_data = d;
                exp_q.push_back('{data: d, idx: 8'(resp_addr - BASE)});
                sum_model = sum_model + d;
            end else begin
                rd_data = 8'($urandom);
            end
            s_rd_data = s_resp_pend ? 8'hFF : 8'($urandom);
        end
    end

    // Consumer ready pattern
    initial begin
        int ph = 0;
        byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (ready_mode)
                0: byte_ready = 1'b1;
                1: byte_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor for the main instance
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        resp_pend = 1'b0;
        if (!rst) begin
            if (write_IO || read_IO) begin
                chk("strobe_excl", {31'd0, write_IO & read_IO}, 32'd0);
                chk("get_data", {31'd0, get_data}, {31'd0, read_IO});
            end
            if (read_IO) begin
                chk("rd_addr", {16'd0, addr}, BASE + n_reads);
                n_reads++;
                resp_pend = 1'b1;
                resp_addr = addr;
            end
            if (write_IO) begin
                chk("wr_addr", {31'd0, (addr == START) || (addr == ACK)}, 32'd1);
                if (addr == START) begin n_start++; start_cyc = cyc; end
                if (addr == ACK) begin n_ack++; ack_cyc = cyc; ack_tmo = timeout_err; end
            end
            if (done) n_done++;
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {16'd0, byte_idx, byte_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_out", {24'd0, byte_out}, {24'd0, e.data});
                    chk("byte_idx", {24'd0, byte_idx}, {24'd0, e.idx});
                    n_acc++;
                end
            end
            if (byte_valid) chk("fifo_depth", {31'd0, exp_q.size() <= 2}, 32'd1);
        end
    end

    // Monitor for the short-transfer instance
    always @(negedge clk) begin
        s_resp_pend = 1'b0;
        if (!rst) begin
            if (s_read_IO) begin
                chk("s_rd_addr", {16'd0, s_addr}, BASE + s_reads);
                s_reads++;
                s_resp_pend = 1'b1;
            end
            if (s_done) s_done_n++;
            if (s_byte_valid && s_byte_ready) begin
                chk("s_byte_out", {24'd0, s_byte_out}, 32'hFF);
                chk("s_byte_idx", {24'd0, s_byte_idx}, s_acc);
                s_acc++;
            end
        end
    end

    task automatic clear_model();
        n_reads = 0; n_start = 0; n_ack = 0; n_done = 0; n_acc = 0;
        start_cyc = 0; ack_cyc = 0; ack_tmo = 1'b0;
        sum_model = 8'd0;
        exp_q.delete();
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int t = 0;
        while (n_start == 0 && t < 20) begin @(negedge clk); t++; end
        chk({tag, "_start_seen"}, n_start, 1);
    endtask

    // One full transfer; irq_delay < 0 means interrupt never rises.
    task automatic run_xfer(input string tag, input int dmode, input int rmode,
                            input int irq_delay, input int busy_go_at,
                            input bit use_const, input logic [7:0] exp_const);
        int t = 0;
        bit sent = 0;
        int exp_reads = (irq_delay < 0) ? 0 : NB;
        data_mode = dmode;
        ready_mode = rmode;
        clear_model();
        pulse_go();
        wait_start(tag);
        if (irq_delay >= 0) begin
            repeat (irq_delay) @(posedge clk);
            #1 interrupt = 1'b1;
        end
        while (n_done == 0 && t < 5000) begin
            @(negedge clk);
            t++;
            if (go) go = 1'b0;
            if (busy_go_at >= 0 && !sent && n_reads == busy_go_at) begin
                go = 1'b1;
                sent = 1;
            end
        end
        go = 1'b0;
        repeat (3) @(negedge clk);
        interrupt = 1'b0;
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_start_writes"}, n_start, 1);
        chk({tag, "_ack_writes"}, n_ack, 1);
        chk({tag, "_reads"}, n_reads, exp_reads);
        chk({tag, "_accepted"}, n_acc, exp_reads);
        chk({tag, "_leftover"}, exp_q.size(), 0);
        chk({tag, "_checksum"}, {24'd0, checksum}, {24'd0, sum_model});
        if (use_const) chk({tag, "_checksum_const"}, {24'd0, checksum}, {24'd0, exp_const});
        chk({tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, irq_delay < 0});
        chk({tag, "_ack_tmo"}, {31'd0, ack_tmo}, {31'd0, irq_delay < 0});
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_valid_idle"}, {31'd0, byte_valid}, 32'd0);
        if (irq_delay < 0) chk({tag, "_tmo_cycles"}, ack_cyc - start_cyc, TMO + 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, {16'd0, addr}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, write_IO, read_IO, get_data}, 32'd0);
        chk({tag, "_flags"}, {28'd0, byte_valid, busy, done, timeout_err}, 32'd0);
        chk({tag, "_checksum"}, {24'd0, checksum}, 32'd0);
    endtask

    initial begin
        int t;
        rst = 1'b1; go = 1'b0; interrupt = 1'b0;
        s_go = 1'b0; s_interrupt = 1'b1; s_byte_ready = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        run_xfer("nominal", 0, 0, 5, -1, 1'b1, 8'h80);
        run_xfer("backpressure", 0, 1, 5, -1, 1'b1, 8'h80);
        run_xfer("timeout", 0, 0, -1, -1, 1'b1, 8'h00);

        // Reset in the middle of the burst
        data_mode = 0; ready_mode = 0;
        clear_model();
        pulse_go();
        wait_start("midrst");
        repeat (5) @(posedge clk);
        #1 interrupt = 1'b1;
        t = 0;
        while (n_reads < 100 && t < 1000) begin @(negedge clk); t++; end
        chk("midrst_reached", {31'd0, n_reads >= 100}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_zero("midrst");
        interrupt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_ack", n_ack, 0);
        run_xfer("after_rst", 0, 0, 5, -1, 1'b1, 8'h80);

        // Random data and consumer, plus a go pulse while busy
        run_xfer("random", 2, 2, 0, 50, 1'b0, 8'h00);

        // Short transfer on the NUM_BYTES=4 instance
        @(posedge clk); #1 s_go = 1'b1;
        @(posedge clk); #1 s_go = 1'b0;
        t = 0;
        while (s_done_n == 0 && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        chk("short_reads", s_reads, SNB);
        chk("short_accepted", s_acc, SNB);
        chk("short_done", s_done_n, 1);
        chk("short_checksum", {24'd0, s_checksum}, {24'd0, 8'(SNB * 255)});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
